// File: rtl/apb_mem_slave_if.sv
// APB bus bundle between a master/decoder and one memory slave.
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA : master -> slave request
//   PRDATA/PREADY/PSLVERR            : slave -> master response
interface apb_mem_slave_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
);
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_mem_slave.sv
// Parametrised APB register-file slave with programmable wait states and
// PSLVERR on out-of-range word addresses.
//   clk   : system clock, rising edge
//   reset : asynchronous active-low reset, clears state and memory
//   apb   : APB slave modport (request in, PRDATA/PREADY/PSLVERR out)
module apb_mem_slave #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  apb_mem_slave_if.slave        apb
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = 4;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [IDX_W-1:0]  r_idx;
  logic              r_write;
  logic [DATA_W-1:0] r_wdata;
  logic              r_err;
  logic [DATA_W-1:0] r_prdata;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_setup;
  logic              w_setup_err;
  logic [IDX_W-1:0]  w_setup_idx;
  logic              w_pready;

  // A setup phase is recognised in either state; in ACCESS it restarts the transfer.
  assign w_setup     = apb.PSEL && !apb.PENABLE;
  assign w_setup_err = (32'(apb.PADDR) >= 32'(DEPTH));
  assign w_setup_idx = apb.PADDR[IDX_W-1:0];

  // Completion decoded from registered state plus the live handshake qualifiers.
  assign w_pready = (r_state == S_ACCESS) && (r_cnt == CNT_W'(WAIT_STATES))
                    && apb.PSEL && apb.PENABLE;

  assign apb.PREADY  = w_pready;
  assign apb.PSLVERR = w_pready && r_err;
  assign apb.PRDATA  = r_prdata;

  // Transfer FSM, wait counter, capture registers and storage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_write  <= 1'b0;
      r_wdata  <= '0;
      r_err    <= 1'b0;
      r_prdata <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_setup) begin
      r_state <= S_ACCESS;
      r_cnt   <= '0;
      r_idx   <= w_setup_idx;
      r_write <= apb.PWRITE;
      r_wdata <= apb.PWDATA;
      r_err   <= w_setup_err;
      // Reads sample memory at setup; PRDATA otherwise holds.
      if (!apb.PWRITE) begin
        r_prdata <= w_setup_err ? '0 : r_mem[w_setup_idx];
      end
    end else if (r_state == S_ACCESS) begin
      if (!apb.PSEL) begin
        r_state <= S_IDLE;
      end else if (w_pready) begin
        if (r_write && !r_err) begin
          r_mem[r_idx] <= r_wdata;
        end
        r_state <= S_IDLE;
      end else if (r_cnt != CNT_W'(WAIT_STATES)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_apb_mem_slave.sv
// Directed bench for apb_mem_slave: three instances (0, 2 and 3 wait states)
// share one stimulus set, gated by per-instance PSEL.
module tb_apb_mem_slave;
  localparam int unsigned DW  = 8;
  localparam int unsigned AW  = 8;
  localparam int unsigned DEP = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  int            sel;
  logic [DW-1:0] prdata;
  logic          pready, pslverr;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  apb_mem_slave_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 ();
  apb_mem_slave_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();
  apb_mem_slave_if #(.ADDR_W(AW), .DATA_W(DW)) bus2 ();

  assign bus0.PSEL = psel && (sel == 0);
  assign bus1.PSEL = psel && (sel == 1);
  assign bus2.PSEL = psel && (sel == 2);
  assign bus0.PENABLE = penable; assign bus1.PENABLE = penable; assign bus2.PENABLE = penable;
  assign bus0.PWRITE  = pwrite;  assign bus1.PWRITE  = pwrite;  assign bus2.PWRITE  = pwrite;
  assign bus0.PADDR   = paddr;   assign bus1.PADDR   = paddr;   assign bus2.PADDR   = paddr;
  assign bus0.PWDATA  = pwdata;  assign bus1.PWDATA  = pwdata;  assign bus2.PWDATA  = pwdata;

  apb_mem_slave #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .apb(bus0.slave));
  apb_mem_slave #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .WAIT_STATES(2)) dut1 (
    .clk(clk), .reset(reset), .apb(bus1.slave));
  apb_mem_slave #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .WAIT_STATES(3)) dut2 (
    .clk(clk), .reset(reset), .apb(bus2.slave));

  always_comb begin
    prdata  = bus0.PRDATA;
    pready  = bus0.PREADY;
    pslverr = bus0.PSLVERR;
    if (sel == 1) begin
      prdata = bus1.PRDATA; pready = bus1.PREADY; pslverr = bus1.PSLVERR;
    end else if (sel == 2) begin
      prdata = bus2.PRDATA; pready = bus2.PREADY; pslverr = bus2.PSLVERR;
    end
  end

  typedef struct {
    int          k;
    logic        wr;
    logic [7:0]  addr;
    logic [7:0]  wdata;
    logic        chk_rd;
    logic [7:0]  exp_rd;
    logic        exp_err;
    int          exp_acc;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive a setup phase right after the next rising edge.
  task automatic setup(input int k, input logic wr, input logic [7:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    sel = k; psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
  endtask

  // Raise PENABLE, then wait (bounded) for PREADY; PADDR/PWDATA are scrambled while waiting.
  task automatic access_wait(output logic [7:0] rd, output logic err, output int acc);
    @(posedge clk); #1;
    penable = 1'b1;
    acc = 0;
    rd = '0;
    err = 1'b0;
    forever begin
      acc++;
      @(negedge clk);
      if (pready) begin
        rd = prdata;
        err = pslverr;
        break;
      end
      if (acc >= 32) begin
        n_checks++;
        n_fail++;
        $display("FAIL timeout waiting for PREADY: got 0 expected 1");
        break;
      end
      @(posedge clk); #1;
      paddr = 8'h0F; pwdata = 8'h00;
    end
  endtask

  task automatic set_vec(input int i, input int k, input logic wr, input logic [7:0] a,
                         input logic [7:0] d, input logic c, input logic [7:0] e,
                         input logic ee, input int ea);
    vecs[i] = '{k, wr, a, d, c, e, ee, ea};
  endtask

  logic [7:0] rd;
  logic       err;
  int         acc;

  initial begin
    // Table of back-to-back transfers with hand-computed results.
    set_vec(0,  0, 1'b0, 8'd3, 8'h00, 1'b1, 8'h00, 1'b0, 1);
    set_vec(1,  0, 1'b1, 8'd2, 8'hA5, 1'b1, 8'h00, 1'b0, 1);   // PRDATA holds across a write
    set_vec(2,  0, 1'b0, 8'd2, 8'h00, 1'b1, 8'hA5, 1'b0, 1);
    set_vec(3,  2, 1'b1, 8'd7, 8'h3C, 1'b0, 8'h00, 1'b0, 4);
    set_vec(4,  2, 1'b0, 8'd7, 8'h00, 1'b1, 8'h3C, 1'b0, 4);
    set_vec(5,  0, 1'b1, 8'd9, 8'hFF, 1'b0, 8'h00, 1'b1, 1);
    set_vec(6,  0, 1'b0, 8'd9, 8'h00, 1'b1, 8'h00, 1'b1, 1);
    set_vec(7,  0, 1'b0, 8'd8, 8'h00, 1'b1, 8'h00, 1'b1, 1);
    for (int a = 0; a < 8; a++) begin
      set_vec(8 + a, 0, 1'b0, 8'(a), 8'h00, 1'b1, (a == 2) ? 8'hA5 : 8'h00, 1'b0, 1);
    end
    set_vec(16, 0, 1'b0, 8'd1, 8'h00, 1'b1, 8'h00, 1'b0, 1);

    reset = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; sel = 0;
    #2;
    for (int k = 0; k < 3; k++) begin
      sel = k; #1;
      chk($sformatf("reset dut%0d prdata", k), 32'(prdata), 32'h0);
      chk($sformatf("reset dut%0d pready", k), 32'(pready), 32'h0);
      chk($sformatf("reset dut%0d pslverr", k), 32'(pslverr), 32'h0);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 17; i++) begin
      setup(vecs[i].k, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      access_wait(rd, err, acc);
      if (vecs[i].chk_rd) chk($sformatf("vec%0d prdata", i), 32'(rd), 32'(vecs[i].exp_rd));
      chk($sformatf("vec%0d pslverr", i), 32'(err), 32'(vecs[i].exp_err));
      chk($sformatf("vec%0d access cycles", i), 32'(acc), 32'(vecs[i].exp_acc));
    end

    // Abort: drop PSEL in the second access cycle of a 2-wait-state write.
    setup(1, 1'b1, 8'd1, 8'h11);
    @(posedge clk); #1; penable = 1'b1;
    @(negedge clk); chk("abort access1 pready", 32'(pready), 32'h0);
    @(posedge clk); #1; psel = 1'b0; penable = 1'b0;
    @(negedge clk); chk("abort access2 pready", 32'(pready), 32'h0);
    setup(1, 1'b0, 8'd1, 8'h00);
    access_wait(rd, err, acc);
    chk("abort readback", 32'(rd), 32'h00);
    chk("abort read cycles", 32'(acc), 32'd3);

    // Illegal PENABLE drop: pending write is discarded, new read setup wins.
    setup(1, 1'b1, 8'd0, 8'h44);
    access_wait(rd, err, acc);
    chk("ws2 write cycles", 32'(acc), 32'd3);
    setup(1, 1'b1, 8'd0, 8'h22);
    @(posedge clk); #1; penable = 1'b1;
    @(posedge clk); #1; penable = 1'b0; pwrite = 1'b0; paddr = 8'd0;
    access_wait(rd, err, acc);
    chk("resetup read data", 32'(rd), 32'h44);
    chk("resetup read cycles", 32'(acc), 32'd3);

    // Reset mid-access of a write.
    setup(0, 1'b1, 8'd4, 8'h5A);
    access_wait(rd, err, acc);
    setup(0, 1'b0, 8'd4, 8'h00);
    access_wait(rd, err, acc);
    chk("pre-reset read addr4", 32'(rd), 32'h5A);
    setup(0, 1'b1, 8'd4, 8'h77);
    @(posedge clk); #1; penable = 1'b1;
    @(negedge clk);
    chk("pre-reset pready", 32'(pready), 32'h1);
    reset = 1'b0;
    #1;
    chk("mid reset prdata", 32'(prdata), 32'h0);
    chk("mid reset pready", 32'(pready), 32'h0);
    chk("mid reset pslverr", 32'(pslverr), 32'h0);
    @(negedge clk);
    reset = 1'b1; psel = 1'b0; penable = 1'b0;
    setup(0, 1'b0, 8'd4, 8'h00);
    access_wait(rd, err, acc);
    chk("post-reset read addr4", 32'(rd), 32'h00);
    setup(0, 1'b0, 8'd2, 8'h00);
    access_wait(rd, err, acc);
    chk("post-reset read addr2", 32'(rd), 32'h00);
    @(posedge clk); #1; psel = 1'b0; penable = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/apb_mem_slave.md
Name: apb_mem_slave

Overview:
Parametrised APB memory-mapped slave and the successor of the fixed 8x8 slaves.
- Register-file storage of configurable width and depth.
- Fully synchronous, clocked APB protocol handling.
- Programmable wait states and PSLVERR for out-of-range accesses.
- Sits behind the APB master/decoder as one of the PSELx targets; PRDATA/PREADY/PSLVERR feed the slave-response mux.

Parameters:
DATA_W, 8, data bus and storage word width (1..32)
ADDR_W, 8, PADDR width
DEPTH, 8, number of storage words (2..256, DEPTH <= 2**ADDR_W)
WAIT_STATES, 0, extra access-phase cycles before PREADY (0..15)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous active-low reset
PSEL  input  1  slave select
PENABLE  input  1  access-phase indicator
PWRITE  input  1  1 = write, 0 = read
PADDR  input  ADDR_W  word address (index = PADDR, no byte offset)
PWDATA  input  DATA_W  write data
PRDATA  output  DATA_W  read data, valid when PREADY=1 on a read
PREADY  output  1  transfer completion
PSLVERR  output  1  error response, valid only when PREADY=1

Behaviour:
Reset (reset=0, asynchronous):
- State=IDLE, wait counter=0, PRDATA=0, PREADY=0, PSLVERR=0.
- All DEPTH memory words are cleared to 0.

FSM states: IDLE, ACCESS.
- IDLE -> ACCESS on an edge with PSEL=1, PENABLE=0 (setup phase).
  - Capture PADDR, PWRITE, PWDATA into internal registers.
  - Wait counter := 0.
  - Compute err = (PADDR >= DEPTH).
  - On a read: PRDATA := err ? 0 : mem[PADDR].
- ACCESS, PSEL=1, PENABLE=1: counter increments each cycle until it reaches WAIT_STATES, then holds.
- PREADY = (state==ACCESS) && (counter==WAIT_STATES) && PSEL && PENABLE.
  - This is decoded from registered state, no combinational path from PADDR/PWDATA.
  - Latency: PREADY is high in access cycle number WAIT_STATES+1. With WAIT_STATES=0 the transfer completes in the first access cycle.
- Completion edge (PREADY=1):
  - Write with err=0: mem[captured addr] := captured data.
  - Write with err=1: memory is unchanged.
  - State -> IDLE.
- PSLVERR = PREADY && err.
- PRDATA holds its value until the next read setup or reset. It is not forced to 0 after a write.
- Back-to-back transfers:
  - Next setup phase immediately after completion: IDLE on that cycle, ACCESS on the following edge. No lost cycle versus the APB spec.
- Protocol abort: PSEL=0 while in ACCESS.
  - State -> IDLE, no memory update, PREADY/PSLVERR stay 0.
- PENABLE=0 while in ACCESS with PSEL=1 (illegal):
  - Treated as a new setup phase.
  - Re-capture all inputs, restart the counter, and discard the previous transfer with no write.
- Wait-state read: mem is sampled at setup. Same-address write ordering is preserved because transfers are strictly serial.
- PADDR/PWDATA changes during ACCESS are ignored; captured values are used.
- Reset asserted mid-transfer: the transfer is aborted, no write occurs, and all outputs go to their reset values immediately.

Test Plan:
- Reset, then read addr 3 (WAIT_STATES=0) -> PREADY=1 in first access cycle, PRDATA=0x00, PSLVERR=0.
- Write 0xA5 to addr 2, then read addr 2 back-to-back -> each transfer 2 cycles (setup+access); read returns 0xA5, no idle cycle required between transfers.
- WAIT_STATES=3: write 0x3C to addr 7, then read -> PREADY low for 3 access cycles, high on 4th; memory updates only on the completion edge; read returns 0x3C.
- DEPTH=8: write 0xFF to addr 9, then read addr 9 -> both complete with PSLVERR=1; read PRDATA=0; a read of every addr 0..7 shows no corruption.
- WAIT_STATES=2: start write 0x11 to addr 1, drop PSEL in the second access cycle -> no PREADY; addr 1 still reads its prior value (0x00).
- Write 0x5A to addr 4, assert reset for 1 cycle mid-access of a following write to addr 4 -> outputs are 0 immediately; after release, addr 4 reads 0x00 because memory is cleared.
